// File: rtl/shifter_arbiter_if.sv
// Bus bundle for shifter_arbiter: two request channels, the tagged response
// channel and the link to the external barrel shifter.
interface shifter_arbiter_if #(
  parameter int N = 16,
  parameter int C = 4
);
  logic         req0_valid;
  logic         req0_ready;
  logic [N-1:0] req0_data;
  logic [C-1:0] req0_cnt;
  logic [1:0]   req0_op;

  logic         req1_valid;
  logic         req1_ready;
  logic [N-1:0] req1_data;
  logic [C-1:0] req1_cnt;
  logic [1:0]   req1_op;

  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [N-1:0] rsp_data;

  logic [N-1:0] sh_in;
  logic [C-1:0] sh_cnt;
  logic [1:0]   sh_op;
  logic [N-1:0] sh_out;

  modport slave (
    input  req0_valid, req0_data, req0_cnt, req0_op,
    output req0_ready,
    input  req1_valid, req1_data, req1_cnt, req1_op,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_data,
    input  rsp_ready,
    output sh_in, sh_cnt, sh_op,
    input  sh_out
  );

  modport master (
    output req0_valid, req0_data, req0_cnt, req0_op,
    input  req0_ready,
    output req1_valid, req1_data, req1_cnt, req1_op,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_data,
    output rsp_ready,
    input  sh_in, sh_cnt, sh_op,
    output sh_out
  );
endinterface

// File: rtl/shifter_arbiter.sv
// Shares one external barrel shifter between two requesters and returns tagged results.
// Define SHARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is fixed priority to port 0.
//
// state | meaning
// IDLE  | waiting for a request; ready goes to the granted port
// SHIFT | operands registered onto sh_*; sh_out captured at end of cycle
// RESP  | result held on rsp_* until the consumer takes it
module shifter_arbiter #(
  parameter int N = 16,
  parameter int C = 4
) (
  input logic             clk,
  input logic             rst_n,
  shifter_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic         grant;
  logic         accept;
  logic         ready0;
  logic         ready1;
  logic         any_valid;

  logic [N-1:0] sel_data;
  logic [C-1:0] sel_cnt;
  logic [1:0]   sel_op;

  logic [N-1:0] opd_data;
  logic [C-1:0] opd_cnt;
  logic [1:0]   opd_op;
  logic [N-1:0] rsp_data_q;
  logic         rsp_id_q;

  assign any_valid = bus.req0_valid | bus.req1_valid;

`ifdef SHARB_ROUND_ROBIN_EN
  logic last_grant;

  // On a tie the port that lost last time wins; reset value lets port 0 win first.
  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) grant = ~last_grant;
    else if (bus.req1_valid)              grant = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_grant <= 1'b1;
    else if (accept) last_grant <= grant;
  end
`else
  assign grant = bus.req1_valid & ~bus.req0_valid;
`endif

  assign sel_data = grant ? bus.req1_data : bus.req0_data;
  assign sel_cnt  = grant ? bus.req1_cnt  : bus.req0_cnt;
  assign sel_op   = grant ? bus.req1_op   : bus.req0_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    ready0    = 1'b0;
    ready1    = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          accept    = 1'b1;
          ready0    = ~grant;
          ready1    = grant;
          state_nxt = (sel_cnt != '0) ? SHIFT : RESP;
        end
      end
      SHIFT: state_nxt = RESP;
      RESP: begin
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A zero count bypasses the shifter, so the operand registers keep their old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opd_data   <= '0;
      opd_cnt    <= '0;
      opd_op     <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= 1'b0;
    end else begin
      if (accept) begin
        rsp_id_q <= grant;
        if (sel_cnt != '0) begin
          opd_data <= sel_data;
          opd_cnt  <= sel_cnt;
          opd_op   <= sel_op;
        end else begin
          rsp_data_q <= sel_data;
        end
      end
      if (state == SHIFT) rsp_data_q <= bus.sh_out;
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.sh_in      = opd_data;
  assign bus.sh_cnt     = opd_cnt;
  assign bus.sh_op      = opd_op;

endmodule

// File: tb/tb_shifter_arbiter.sv
// Self-checking bench for shifter_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model and a bit-stepping shift reference.
module tb_shifter_arbiter;

  logic clk;
  logic rst_n;

  shifter_arbiter_if #(.N(16), .C(4)) bus ();

  shifter_arbiter #(.N(16), .C(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External barrel shifter
  always_comb begin
    bus.sh_out = 16'h0000;
    case (bus.sh_op)
      2'b00: bus.sh_out = (bus.sh_in << bus.sh_cnt) | (bus.sh_in >> (16 - int'(bus.sh_cnt)));
      2'b01: bus.sh_out = bus.sh_in << bus.sh_cnt;
      2'b10: bus.sh_out = (bus.sh_in >> bus.sh_cnt) | (bus.sh_in << (16 - int'(bus.sh_cnt)));
      2'b11: bus.sh_out = bus.sh_in >> bus.sh_cnt;
      default: bus.sh_out = 16'h0000;
    endcase
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference result: apply the op one bit position at a time
  function automatic logic [15:0] ref_shift(input logic [15:0] d, input int c, input logic [1:0] op);
    logic [15:0] r;
    r = d;
    for (int i = 0; i < c; i++) begin
      case (op)
        2'b00: r = {r[14:0], r[15]};
        2'b01: r = {r[14:0], 1'b0};
        2'b10: r = {r[0], r[15:1]};
        default: r = {1'b0, r[15:1]};
      endcase
    end
    return r;
  endfunction

  // Transaction model state
  int          cyc = 0;
  bit          busy = 0;
  bit          prev_win = 1;
  int          acc_cyc = 0;
  int          exp_lat = 0;
  logic        exp_id;
  logic [15:0] exp_data;
  logic [15:0] model_sh_in = 0;
  logic [3:0]  model_sh_cnt = 0;
  logic [1:0]  model_sh_op = 0;
  bit          acc0 = 0;
  bit          acc1 = 0;
  int          n_acc = 0;
  int          n_rsp = 0;
  int          hs_cyc = 0;
  logic [15:0] last_rsp_data;
  logic        last_rsp_id;
  int          glog[$];
  int          clog[$];

  always @(negedge clk) begin
    acc0 = 0;
    acc1 = 0;
    if (!rst_n) begin
      busy         = 0;
      prev_win     = 1;
      model_sh_in  = 0;
      model_sh_cnt = 0;
      model_sh_op  = 0;
    end else begin
      cyc++;
      chk("sh_in", bus.sh_in, model_sh_in);
      chk("sh_cnt", bus.sh_cnt, model_sh_cnt);
      chk("sh_op", bus.sh_op, model_sh_op);
      if (busy) begin
        chk("ready_busy", {bus.req1_ready, bus.req0_ready}, 2'b00);
        chk("rsp_valid", bus.rsp_valid, (cyc - acc_cyc) >= exp_lat);
        if (bus.rsp_valid && (cyc - acc_cyc) >= exp_lat) begin
          chk("rsp_id", bus.rsp_id, exp_id);
          chk("rsp_data", bus.rsp_data, exp_data);
          if (bus.rsp_ready) begin
            busy          = 0;
            hs_cyc        = cyc;
            last_rsp_data = bus.rsp_data;
            last_rsp_id   = bus.rsp_id;
            n_rsp++;
          end
        end
      end else begin
        bit w;
        bit any;
        any = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
`ifdef SHARB_ROUND_ROBIN_EN
          w = ~prev_win;
`else
          w = 0;
`endif
        end else begin
          w = bus.req1_valid;
        end
        chk("rsp_valid_idle", bus.rsp_valid, 1'b0);
        chk("ready", {bus.req1_ready, bus.req0_ready}, !any ? 2'b00 : (w ? 2'b10 : 2'b01));
        if (any) begin
          logic [15:0] d;
          logic [3:0]  c;
          logic [1:0]  o;
          d = w ? bus.req1_data : bus.req0_data;
          c = w ? bus.req1_cnt  : bus.req0_cnt;
          o = w ? bus.req1_op   : bus.req0_op;
          exp_data = ref_shift(d, int'(c), o);
          exp_id   = w;
          exp_lat  = (c == 0) ? 1 : 2;
          acc_cyc  = cyc;
          busy     = 1;
          prev_win = w;
          if (c != 0) begin
            model_sh_in  = d;
            model_sh_cnt = c;
            model_sh_op  = o;
          end
          if (w) acc1 = 1;
          else   acc0 = 1;
          glog.push_back(int'(w));
          clog.push_back(cyc);
          n_acc++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int p, input logic [15:0] d, input logic [3:0] c, input logic [1:0] o);
    bit got;
    got = 0;
    if (p == 0) begin
      bus.req0_valid = 1; bus.req0_data = d; bus.req0_cnt = c; bus.req0_op = o;
    end else begin
      bus.req1_valid = 1; bus.req1_data = d; bus.req1_cnt = c; bus.req1_op = o;
    end
    for (int k = 0; k < 40 && !got; k++) begin
      tick();
      got = (p == 0) ? acc0 : acc1;
    end
    chk("accept_seen", got, 1'b1);
    if (p == 0) bus.req0_valid = 0;
    else        bus.req1_valid = 0;
  endtask

  task automatic wait_rsp(input int base);
    for (int k = 0; k < 40 && n_rsp <= base; k++) tick();
    chk("rsp_seen", n_rsp > base, 1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    int bp_ok;

    rst_n = 0;
    bus.req0_valid = 0; bus.req0_data = 0; bus.req0_cnt = 0; bus.req0_op = 0;
    bus.req1_valid = 0; bus.req1_data = 0; bus.req1_cnt = 0; bus.req1_op = 0;
    bus.rsp_ready = 1;
    #1;
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_id", bus.rsp_id, 1'b0);
    chk("rst_rsp_data", bus.rsp_data, 16'h0000);
    chk("rst_sh_in", bus.sh_in, 16'h0000);
    chk("rst_sh_cnt", bus.sh_cnt, 4'h0);
    chk("rst_sh_op", bus.sh_op, 2'b00);
    repeat (3) tick();
    rst_n = 1;
    tick();

    // Basic rotate/shift transactions
    base = n_rsp; issue(0, 16'h8001, 4'd1, 2'b00); wait_rsp(base);
    chk("t_rotl_data", last_rsp_data, 16'h0003);
    chk("t_rotl_id", last_rsp_id, 1'b0);
    base = n_rsp; issue(1, 16'hF000, 4'd4, 2'b11); wait_rsp(base);
    chk("t_srl_data", last_rsp_data, 16'h0F00);
    chk("t_srl_id", last_rsp_id, 1'b1);
    base = n_rsp; issue(1, 16'h000F, 4'd4, 2'b10); wait_rsp(base);
    chk("t_rotr_data", last_rsp_data, 16'hF000);

    // Zero count bypass: shifter operand untouched
    base = n_rsp; issue(0, 16'h1234, 4'd0, 2'b00); wait_rsp(base);
    chk("t_bypass_data", last_rsp_data, 16'h1234);
    chk("t_bypass_sh_in", bus.sh_in, 16'h000F);
    chk("t_bypass_lat", hs_cyc - clog[clog.size()-1], 1);

    // Backpressure: rsp_ready low for 5 cycles while requester 1 waits
    bus.rsp_ready = 0;
    issue(0, 16'hA5A5, 4'd3, 2'b01);
    bus.req1_valid = 1; bus.req1_data = 16'h0101; bus.req1_cnt = 4'd1; bus.req1_op = 2'b01;
    for (int k = 0; k < 10 && !bus.rsp_valid; k++) tick();
    chk("bp_valid", bus.rsp_valid, 1'b1);
    for (int k = 0; k < 5; k++) begin
      chk("bp_ready", {bus.req1_ready, bus.req0_ready}, 2'b00);
      chk("bp_data", bus.rsp_data, 16'h2D28);
      chk("bp_id", bus.rsp_id, 1'b0);
      tick();
    end
    base = n_rsp;
    bus.rsp_ready = 1;
    bp_ok = 0;
    for (int k = 0; k < 10 && !bp_ok; k++) begin
      tick();
      bp_ok = acc1;
    end
    chk("bp_next_accept", bp_ok, 1'b1);
    chk("bp_accept_gap", clog[clog.size()-1] - hs_cyc, 1);
    bus.req1_valid = 0;
    wait_rsp(base + 1);
    chk("bp_second_data", last_rsp_data, 16'h0202);

    // Reset during SHIFT
    issue(0, 16'h1111, 4'd2, 2'b00);
    rst_n = 0;
    #1;
    chk("mid_rst_valid", bus.rsp_valid, 1'b0);
    chk("mid_rst_data", bus.rsp_data, 16'h0000);
    chk("mid_rst_sh_in", bus.sh_in, 16'h0000);
    chk("mid_rst_id", bus.rsp_id, 1'b0);
    tick();
    rst_n = 1;
    base = n_rsp;
    repeat (4) tick();
    chk("mid_rst_no_rsp", n_rsp, base);

    // Both requesters valid continuously
    base = glog.size();
    bus.req0_valid = 1; bus.req0_data = 16'h00F0; bus.req0_cnt = 4'd1; bus.req0_op = 2'b01;
    bus.req1_valid = 1; bus.req1_data = 16'h0F00; bus.req1_cnt = 4'd2; bus.req1_op = 2'b11;
    for (int k = 0; k < 60 && glog.size() < base + 6; k++) tick();
    bus.req0_valid = 0;
    bus.req1_valid = 0;
    chk("both_count", glog.size() >= base + 6, 1'b1);
    for (int i = 0; i < 6 && base + i < glog.size(); i++) begin
`ifdef SHARB_ROUND_ROBIN_EN
      chk("both_grant", glog[base+i], i % 2);
`else
      chk("both_grant", glog[base+i], 0);
`endif
      if (i > 0) chk("both_spacing", clog[base+i] - clog[base+i-1], 3);
    end
    repeat (5) tick();

    // Randomized traffic
    begin
      int a0;
      int r0;
      a0 = n_acc;
      r0 = n_rsp;
      for (int t = 0; t < 2000; t++) begin
        if (!bus.req0_valid || acc0) begin
          bus.req0_valid = ($urandom % 3) != 0;
          bus.req0_data  = 16'($urandom);
          bus.req0_cnt   = (($urandom % 4) == 0) ? 4'd0 : 4'($urandom);
          bus.req0_op    = 2'($urandom);
        end else if (($urandom % 4) == 0) begin
          bus.req0_data = 16'($urandom);
          bus.req0_cnt  = 4'($urandom);
        end
        if (!bus.req1_valid || acc1) begin
          bus.req1_valid = ($urandom % 3) != 0;
          bus.req1_data  = 16'($urandom);
          bus.req1_cnt   = (($urandom % 4) == 0) ? 4'd0 : 4'($urandom);
          bus.req1_op    = 2'($urandom);
        end else if (($urandom % 4) == 0) begin
          bus.req1_data = 16'($urandom);
          bus.req1_op   = 2'($urandom);
        end
        bus.rsp_ready = ($urandom % 4) != 0;
        tick();
      end
      bus.req0_valid = 0;
      bus.req1_valid = 0;
      bus.rsp_ready  = 1;
      repeat (8) tick();
      chk("rand_activity", (n_acc - a0) > 200, 1'b1);
      chk("rand_all_returned", n_rsp - r0, n_acc - a0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
